// File: rtl/bc_dst_wrctl_if.sv
// Bus-connect write-side signal bundle: sequencer request, DAG/PS write ports, crossbar handshake.
// Pure wiring, no latency of its own.
// Backpressure is carried by bc_ps_stall (to sequencer) and xb_bc_rdy (from crossbar).
// Optional parity output bc_xb_par exists only when BC_DST_XB_PARITY_EN is defined.
interface bc_dst_wrctl_if #(
   parameter int DW = 16,
   parameter int AW = 4
);
   logic [DW-1:0] bc_dt;
   logic          ps_bc_dst_vld;
   logic [1:0]    ps_bc_dst_sclt;
   logic [AW-1:0] ps_bc_dst_add;
   logic [DW-1:0] bc_dg_wrdt;
   logic [AW-1:0] bc_dg_wadd;
   logic          bc_dg_wen;
   logic [DW-1:0] bc_ps_wrdt;
   logic [AW-1:0] bc_ps_wadd;
   logic          bc_ps_wen;
   logic [DW-1:0] bc_xb_dtx;
   logic          bc_xb_vld;
   logic          xb_bc_rdy;
   logic          bc_ps_stall;
`ifdef BC_DST_XB_PARITY_EN
   logic          bc_xb_par;
`endif

   // Write controller side: consumes requests, drives destinations.
   modport master (
`ifdef BC_DST_XB_PARITY_EN
      output bc_xb_par,
`endif
      input  bc_dt, ps_bc_dst_vld, ps_bc_dst_sclt, ps_bc_dst_add, xb_bc_rdy,
      output bc_dg_wrdt, bc_dg_wadd, bc_dg_wen,
      output bc_ps_wrdt, bc_ps_wadd, bc_ps_wen,
      output bc_xb_dtx, bc_xb_vld, bc_ps_stall
   );

   // Sequencer / destination side.
   modport slave (
`ifdef BC_DST_XB_PARITY_EN
      input  bc_xb_par,
`endif
      output bc_dt, ps_bc_dst_vld, ps_bc_dst_sclt, ps_bc_dst_add, xb_bc_rdy,
      input  bc_dg_wrdt, bc_dg_wadd, bc_dg_wen,
      input  bc_ps_wrdt, bc_ps_wadd, bc_ps_wen,
      input  bc_xb_dtx, bc_xb_vld, bc_ps_stall
   );
endinterface

// File: rtl/bc_dst_wrctl.sv
// Bus-connect write controller: routes bc_dt to DAG/PS register strobes or a crossbar FIFO.
// Latency: DAG/PS 1 clock; crossbar 1 clock minimum (no empty bypass).
// Backpressure: xb_bc_rdy low fills the FIFO; bc_ps_stall (full) rejects crossbar requests.
// Optional macro BC_DST_XB_PARITY_EN adds a stored per-entry even-parity bit on bc_xb_par.
module bc_dst_wrctl #(
   parameter int DW       = 16,
   parameter int AW       = 4,
   parameter int XB_DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   bc_dst_wrctl_if.master bus
);
   localparam int PTW = $clog2(XB_DEPTH);
   localparam int CW  = PTW + 1;
`ifdef BC_DST_XB_PARITY_EN
   localparam int EW  = DW + 1;
`else
   localparam int EW  = DW;
`endif
   localparam logic [CW-1:0] FULL = CW'(XB_DEPTH);

   logic [DW-1:0]  dg_wrdt_q, dg_wrdt_d;
   logic [AW-1:0]  dg_wadd_q, dg_wadd_d;
   logic           dg_wen_q,  dg_wen_d;
   logic [DW-1:0]  ps_wrdt_q, ps_wrdt_d;
   logic [AW-1:0]  ps_wadd_q, ps_wadd_d;
   logic           ps_wen_q,  ps_wen_d;
   logic [EW-1:0]  mem_q [XB_DEPTH];
   logic [EW-1:0]  mem_d [XB_DEPTH];
   logic [PTW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   logic           stall, accept, push, pop;
   logic [EW-1:0]  push_entry;

   // Request qualification: stall depends on count alone, so a same-cycle pop never frees a slot.
   always_comb begin
      stall  = (cnt_q == FULL);
      accept = bus.ps_bc_dst_vld && !(bus.ps_bc_dst_sclt == 2'b10 && stall);
      push   = accept && (bus.ps_bc_dst_sclt == 2'b10);
      pop    = (cnt_q != '0) && bus.xb_bc_rdy;
`ifdef BC_DST_XB_PARITY_EN
      push_entry = {^bus.bc_dt, bus.bc_dt};
`else
      push_entry = bus.bc_dt;
`endif
   end

   // DAG/PS register ports: one-cycle strobe, data/address hold between writes.
   always_comb begin
      dg_wen_d  = accept && (bus.ps_bc_dst_sclt == 2'b00);
      dg_wrdt_d = dg_wen_d ? bus.bc_dt : dg_wrdt_q;
      dg_wadd_d = dg_wen_d ? bus.ps_bc_dst_add : dg_wadd_q;
      ps_wen_d  = accept && (bus.ps_bc_dst_sclt == 2'b01);
      ps_wrdt_d = ps_wen_d ? bus.bc_dt : ps_wrdt_q;
      ps_wadd_d = ps_wen_d ? bus.ps_bc_dst_add : ps_wadd_q;
   end

   // Crossbar FIFO next state; pointers wrap for free since depth is a power of two.
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d = push ? wr_ptr_q + PTW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTW'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // State registers; reset clears storage too so bc_xb_dtx reads 0 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dg_wrdt_q <= '0;
         dg_wadd_q <= '0;
         dg_wen_q  <= 1'b0;
         ps_wrdt_q <= '0;
         ps_wadd_q <= '0;
         ps_wen_q  <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         for (int i = 0; i < XB_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         dg_wrdt_q <= dg_wrdt_d;
         dg_wadd_q <= dg_wadd_d;
         dg_wen_q  <= dg_wen_d;
         ps_wrdt_q <= ps_wrdt_d;
         ps_wadd_q <= ps_wadd_d;
         ps_wen_q  <= ps_wen_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         for (int i = 0; i < XB_DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   assign bus.bc_dg_wrdt  = dg_wrdt_q;
   assign bus.bc_dg_wadd  = dg_wadd_q;
   assign bus.bc_dg_wen   = dg_wen_q;
   assign bus.bc_ps_wrdt  = ps_wrdt_q;
   assign bus.bc_ps_wadd  = ps_wadd_q;
   assign bus.bc_ps_wen   = ps_wen_q;
   assign bus.bc_xb_dtx   = mem_q[rd_ptr_q][DW-1:0];
   assign bus.bc_xb_vld   = (cnt_q != '0);
   assign bus.bc_ps_stall = stall;
`ifdef BC_DST_XB_PARITY_EN
   assign bus.bc_xb_par   = mem_q[rd_ptr_q][DW];
`endif
endmodule

// File: tb/tb_bc_dst_wrctl.sv
// Bench for bc_dst_wrctl: directed scenarios then random traffic against a queue-based model.
// Outputs sampled 1 time unit after the rising edge; inputs driven at that point too.
// Parity checks enabled when BC_DST_XB_PARITY_EN is defined.
module tb_bc_dst_wrctl;
   localparam int DW = 16;
   localparam int AW = 4;
   localparam int D  = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;

   bc_dst_wrctl_if #(.DW(DW), .AW(AW)) bus ();

   bc_dst_wrctl #(.DW(DW), .AW(AW), .XB_DEPTH(D)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [DW-1:0] m_q [$];
   logic [DW-1:0] hist [$];
   logic [DW-1:0] popped [$];
   int            npop;
   logic          e_dg_wen, e_ps_wen, last_acc;
   logic [DW-1:0] e_dg_wrdt, e_ps_wrdt;
   logic [AW-1:0] e_dg_wadd, e_ps_wadd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete(); hist.delete(); popped.delete();
      npop = 0;
      e_dg_wen = 0; e_ps_wen = 0; e_dg_wrdt = '0; e_ps_wrdt = '0;
      e_dg_wadd = '0; e_ps_wadd = '0; last_acc = 0;
   endtask

   // FIFO head when non-empty; when empty, the slot at the read position last held push #(npop-D)
   function automatic logic [DW-1:0] exp_dtx();
      if (m_q.size() != 0) return m_q[0];
      if (npop >= D) return hist[npop - D];
      return '0;
   endfunction

   task automatic chk_all(input string tag);
      logic [DW-1:0] ed;
      ed = exp_dtx();
      chk({tag, ".dg_wen"},  32'(bus.bc_dg_wen),   32'(e_dg_wen));
      chk({tag, ".dg_wrdt"}, 32'(bus.bc_dg_wrdt),  32'(e_dg_wrdt));
      chk({tag, ".dg_wadd"}, 32'(bus.bc_dg_wadd),  32'(e_dg_wadd));
      chk({tag, ".ps_wen"},  32'(bus.bc_ps_wen),   32'(e_ps_wen));
      chk({tag, ".ps_wrdt"}, 32'(bus.bc_ps_wrdt),  32'(e_ps_wrdt));
      chk({tag, ".ps_wadd"}, 32'(bus.bc_ps_wadd),  32'(e_ps_wadd));
      chk({tag, ".xb_vld"},  32'(bus.bc_xb_vld),   32'(m_q.size() != 0));
      chk({tag, ".xb_dtx"},  32'(bus.bc_xb_dtx),   32'(ed));
      chk({tag, ".stall"},   32'(bus.bc_ps_stall), 32'(m_q.size() == D));
`ifdef BC_DST_XB_PARITY_EN
      chk({tag, ".xb_par"},  32'(bus.bc_xb_par),   32'(^ed));
`endif
   endtask

   // one clock: drive, advance model by the rules, clock, compare
   task automatic step(input string tag, input logic vld, input logic [1:0] sclt,
                       input logic [AW-1:0] add, input logic [DW-1:0] dt, input logic rdy);
      logic full, pop;
      bus.ps_bc_dst_vld = vld; bus.ps_bc_dst_sclt = sclt; bus.ps_bc_dst_add = add;
      bus.bc_dt = dt; bus.xb_bc_rdy = rdy;
      full     = (m_q.size() == D);
      last_acc = vld && !(sclt == 2'b10 && full);
      pop      = (m_q.size() != 0) && rdy;
      e_dg_wen = last_acc && sclt == 2'b00;
      e_ps_wen = last_acc && sclt == 2'b01;
      if (e_dg_wen) begin e_dg_wrdt = dt; e_dg_wadd = add; end
      if (e_ps_wen) begin e_ps_wrdt = dt; e_ps_wadd = add; end
      if (pop) begin popped.push_back(m_q.pop_front()); npop++; end
      if (last_acc && sclt == 2'b10) begin m_q.push_back(dt); hist.push_back(dt); end
      @(posedge clk); #1;
      chk_all(tag);
   endtask

   task automatic idle(input string tag, input logic rdy);
      step(tag, 1'b0, 2'b11, '0, '0, rdy);
   endtask

   initial begin
      int nxt;
      logic [DW-1:0] exp_order [6];
      model_reset();

      // reset held with random inputs
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.ps_bc_dst_vld = 1'($urandom); bus.ps_bc_dst_sclt = 2'($urandom);
         bus.ps_bc_dst_add = 4'($urandom); bus.bc_dt = 16'($urandom); bus.xb_bc_rdy = 1'($urandom);
         @(posedge clk); #1;
         chk_all("rst_hold");
      end
      bus.ps_bc_dst_vld = 1'b0;
      rst_n = 1'b1;
      idle("rst_rel0", 1'b0);
      idle("rst_rel1", 1'b1);

      // DAG then PS write
      step("dag_wr", 1'b1, 2'b00, 4'd3, 16'hA5A5, 1'b0);
      chk("dag_wrdt_abs", 32'(bus.bc_dg_wrdt), 32'h0000A5A5);
      step("ps_wr", 1'b1, 2'b01, 4'd7, 16'h1234, 1'b0);
      chk("ps_wrdt_abs", 32'(bus.bc_ps_wrdt), 32'h00001234);
      idle("dgps_done", 1'b0);

      // fill with rdy low: 5th push dropped
      for (int i = 1; i <= 5; i++) step("fill", 1'b1, 2'b10, '0, 16'(i), 1'b0);
      chk("fill_stall_abs", 32'(bus.bc_ps_stall), 32'd1);
      chk("fill_head_abs", 32'(bus.bc_xb_dtx), 32'h0001);
      idle("fill_hold", 1'b0);

      // drain with wrap, reissuing 6 and 7 as stall clears
      popped.delete();
      nxt = 6;
      for (int i = 0; i < 6; i++) begin
         step("drain", nxt <= 7, 2'b10, '0, 16'(nxt), 1'b1);
         if (last_acc) nxt++;
      end
      exp_order = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h6, 16'h7};
      chk("drain_cnt", 32'(popped.size()), 32'd6);
      for (int i = 0; i < 6 && i < popped.size(); i++) chk("drain_order", 32'(popped[i]), 32'(exp_order[i]));
      chk("drain_empty_abs", 32'(bus.bc_xb_vld), 32'd0);

      // simultaneous push/pop at count 2, then none-select
      step("pp_a", 1'b1, 2'b10, '0, 16'h00AA, 1'b0);
      step("pp_b", 1'b1, 2'b10, '0, 16'h00BB, 1'b0);
      step("pp_both", 1'b1, 2'b10, '0, 16'h00CC, 1'b1);
      chk("pp_head_abs", 32'(bus.bc_xb_dtx), 32'h00BB);
      step("none_sel", 1'b1, 2'b11, 4'd5, 16'hFFFF, 1'b0);
      chk("none_no_dg", 32'(bus.bc_dg_wen), 32'd0);

      // async reset mid-operation (FIFO holds 2, push one more to reach 3)
      step("pre_rst", 1'b1, 2'b10, '0, 16'h00DD, 1'b0);
      bus.ps_bc_dst_vld = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_vld", 32'(bus.bc_xb_vld), 32'd0);
      chk("async_rst_dtx", 32'(bus.bc_xb_dtx), 32'd0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      step("post_rst_push", 1'b1, 2'b10, '0, 16'h0007, 1'b0);
      chk("post_rst_head_abs", 32'(bus.bc_xb_dtx), 32'h0007);
`ifdef BC_DST_XB_PARITY_EN
      chk("par_7_abs", 32'(bus.bc_xb_par), 32'd1);
`endif
      step("post_rst_alone", 1'b1, 2'b10, '0, 16'h0003, 1'b1);
      chk("post_rst_2nd_abs", 32'(bus.bc_xb_dtx), 32'h0003);
`ifdef BC_DST_XB_PARITY_EN
      chk("par_3_abs", 32'(bus.bc_xb_par), 32'd0);
`endif
      idle("post_rst_drain", 1'b1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom), 16'($urandom),
              1'($urandom_range(0, 2) == 0));
      end
      for (int i = 0; i < D + 1; i++) idle("final_drain", 1'b1);
      chk("final_empty_abs", 32'(bus.bc_xb_vld), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
